// File: rtl/bus_addr_latch_decode.sv
// bus_addr_latch_decode
//   Front-end stage between the 8088 bus interface and the memory/IO slaves.
//   Latches the 20-bit address on ALE, decodes it into one of four slave
//   chip-selects, tracks the bus cycle (address -> strobe -> done) and flags
//   cycles that hit no slave or never strobe.
//
//   Optional feature macro: BUS_CYCLE_COUNT_EN
//     When defined, adds RD_COUNT/WR_COUNT completed-cycle counters.
//
// Ports
//   CLK       in   system clock, all state on rising edge
//   RESET     in   synchronous, active-high reset
//   ALE       in   address latch enable (one cycle in T1)
//   IOM       in   1 = IO cycle, 0 = memory cycle
//   RD, WR    in   active-low read / write strobes
//   AD[19:0]  in   multiplexed address/data bus
//   Address   out  latched address (AD passthrough while ALE is high)
//   CS0..CS3  out  slave selects (decoded passthrough while ALE is high)
//   BUSY      out  bus cycle in progress
//   ERR       out  one-cycle pulse on unmapped, preempted-unstrobed or
//                  timed-out cycle
//   RD_COUNT  out  completed reads  (BUS_CYCLE_COUNT_EN only)
//   WR_COUNT  out  completed writes (BUS_CYCLE_COUNT_EN only)
module bus_addr_latch_decode #(
    parameter logic [19:0] MEM0_LIMIT = 20'h7FFFF,
    parameter logic [15:0] IO2_BASE   = 16'h1C00,
    parameter logic [15:0] IO2_LIMIT  = 16'h1DFF,
    parameter logic [15:0] IO3_BASE   = 16'hFF00,
    parameter logic [15:0] IO3_LIMIT  = 16'hFF0F,
    parameter int          TIMEOUT    = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ALE,
    input  logic        IOM,
    input  logic        RD,
    input  logic        WR,
    input  logic [19:0] AD,
    output logic [19:0] Address,
    output logic        CS0,
    output logic        CS1,
    output logic        CS2,
    output logic        CS3,
    output logic        BUSY,
    output logic        ERR
`ifdef BUS_CYCLE_COUNT_EN
    ,
    output logic [15:0] RD_COUNT,
    output logic [15:0] WR_COUNT
`endif
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_STROBE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [19:0]     addr_q;
    logic [3:0]      cs_q;
    logic [CW-1:0]   cnt_q;
    logic            rd_q, rd_d;     // active strobe of current cycle is RD
    logic [3:0]      dec_cs;
    logic            dec_hit;
    logic            ale;
    logic            err_c;

    // Reset dominates, including the combinational ALE passthrough paths.
    assign ale = ALE & ~RESET;

    // Address decode. IO cycles compare only AD[15:0]; the IO2 test comes
    // first so overlapping IO windows resolve to the lower-numbered select.
    always_comb begin
        dec_cs = 4'b0000;
        if (!IOM) begin
            if (AD <= MEM0_LIMIT) dec_cs[0] = 1'b1;
            else                  dec_cs[1] = 1'b1;
        end else if (AD[15:0] >= IO2_BASE && AD[15:0] <= IO2_LIMIT) begin
            dec_cs[2] = 1'b1;
        end else if (AD[15:0] >= IO3_BASE && AD[15:0] <= IO3_LIMIT) begin
            dec_cs[3] = 1'b1;
        end
    end

    assign dec_hit = |dec_cs;

    // Next state and the ERR pulse. ERR is asserted in the very cycle the
    // fault is recognised: the ALE cycle for unmapped/preempted cycles, the
    // last waiting cycle for a timeout.
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        err_c   = 1'b0;
        if (ale) begin
            state_d = dec_hit ? S_ADDR : S_IDLE;
            err_c   = !dec_hit || (state_q == S_ADDR);
        end else begin
            case (state_q)
                S_IDLE: ;
                S_ADDR: begin
                    if (!RD) begin
                        state_d = S_STROBE;
                        rd_d    = 1'b1;     // RD wins when both are low
                    end else if (!WR) begin
                        state_d = S_STROBE;
                        rd_d    = 1'b0;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d = S_IDLE;
                        err_c   = 1'b1;
                    end
                end
                S_STROBE: begin
                    if (rd_q ? RD : WR) state_d = S_DONE;
                end
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cs_q    <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            if (ale) begin
                addr_q <= AD;
                cs_q   <= dec_cs;
                cnt_q  <= '0;
            end else begin
                if (state_d == S_IDLE) cs_q <= '0;
                if (state_q == S_ADDR && state_d == S_ADDR) cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef BUS_CYCLE_COUNT_EN
    // state_d is S_DONE only when no ALE preempted, so aborts never count.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            RD_COUNT <= '0;
            WR_COUNT <= '0;
        end else if (state_q == S_STROBE && state_d == S_DONE) begin
            if (rd_q) RD_COUNT <= RD_COUNT + 16'd1;
            else      WR_COUNT <= WR_COUNT + 16'd1;
        end
    end
`endif

    assign Address = ale ? AD : addr_q;
    assign {CS3, CS2, CS1, CS0} = ale ? dec_cs : cs_q;
    assign BUSY    = (state_q != S_IDLE);
    assign ERR     = err_c;

endmodule
